// File: rtl/pndng_fifo.sv
// pndng_fifo: single-clock first-word-fall-through FIFO
// with pending/pop consumer handshake and sticky error flags.
module pndng_fifo #(
  parameter int pckg_sz = 32,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Push,
  input  logic [pckg_sz-1:0]         D_in,
  input  logic                       Pop,
  input  logic                       clr_err,
  output logic                       Pndng,
  output logic [pckg_sz-1:0]         D_out,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);

  logic [pckg_sz-1:0] mem [depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               pop_acc;
  logic               wr_acc;

  // Pointers wrap explicitly so any depth works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs come only from registered state.
  always_comb begin
    Pndng = (count != '0);
    full  = (count == CW'(depth));
    D_out = Pndng ? mem[rd_ptr] : '0;
  end

  // Acceptance: a pop frees the slot for a push in the same cycle.
  always_comb begin
    pop_acc = Pop & Pndng;
    wr_acc  = Push & (~full | pop_acc);
  end

  // Storage array, intentionally not reset; D_out masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= D_in;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc) rd_ptr <= ptr_inc(rd_ptr);
      unique case (1'b1)
        wr_acc & ~pop_acc: count <= count + CW'(1);
        pop_acc & ~wr_acc: count <= count - CW'(1);
        default:           count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (ovf & ~clr_err) | (Push & ~wr_acc);
      unf <= (unf & ~clr_err) | (Pop & ~pop_acc);
    end
  end

endmodule

// File: tb/tb_pndng_fifo.sv
// tb_pndng_fifo: directed and random checks of pndng_fifo
// against a queue model, at depth 8 and depth 5.
module tb_pndng_fifo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         push8 = 1'b0;
  logic         pop8 = 1'b0;
  logic         clr8 = 1'b0;
  logic [W-1:0] din8 = '0;
  logic         pndng8, full8, ovf8, unf8;
  logic [W-1:0] dout8;
  logic [3:0]   cnt8;

  logic         push5 = 1'b0;
  logic         pop5 = 1'b0;
  logic         clr5 = 1'b0;
  logic [W-1:0] din5 = '0;
  logic         pndng5, full5, ovf5, unf5;
  logic [W-1:0] dout5;
  logic [2:0]   cnt5;

  int total = 0;
  int bad = 0;

  logic [W-1:0] q8[$];
  logic [W-1:0] q5[$];
  logic         ovf8_m = 1'b0;
  logic         unf8_m = 1'b0;
  logic         ovf5_m = 1'b0;
  logic         unf5_m = 1'b0;

  pndng_fifo #(.pckg_sz(W), .depth(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .Push(push8), .D_in(din8),
    .Pop(pop8), .clr_err(clr8),
    .Pndng(pndng8), .D_out(dout8),
    .full(full8), .count(cnt8),
    .ovf(ovf8), .unf(unf8)
  );

  pndng_fifo #(.pckg_sz(W), .depth(5)) u5 (
    .clk(clk), .rst_n(rst_n),
    .Push(push5), .D_in(din5),
    .Pop(pop5), .clr_err(clr5),
    .Pndng(pndng5), .D_out(dout5),
    .full(full5), .count(cnt5),
    .ovf(ovf5), .unf(unf5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check8(input string t);
    logic [W-1:0] h;
    h = (q8.size() > 0) ? q8[0] : '0;
    chk({t, "/cnt8"}, 64'(cnt8), 64'(q8.size()));
    chk({t, "/pndng8"}, 64'(pndng8), 64'(q8.size() > 0));
    chk({t, "/full8"}, 64'(full8), 64'(q8.size() == 8));
    chk({t, "/dout8"}, 64'(dout8), 64'(h));
    chk({t, "/ovf8"}, 64'(ovf8), 64'(ovf8_m));
    chk({t, "/unf8"}, 64'(unf8), 64'(unf8_m));
  endtask

  task automatic check5(input string t);
    logic [W-1:0] h;
    h = (q5.size() > 0) ? q5[0] : '0;
    chk({t, "/cnt5"}, 64'(cnt5), 64'(q5.size()));
    chk({t, "/pndng5"}, 64'(pndng5), 64'(q5.size() > 0));
    chk({t, "/full5"}, 64'(full5), 64'(q5.size() == 5));
    chk({t, "/dout5"}, 64'(dout5), 64'(h));
    chk({t, "/ovf5"}, 64'(ovf5), 64'(ovf5_m));
    chk({t, "/unf5"}, 64'(unf5), 64'(unf5_m));
  endtask

  // One clock of stimulus on the depth-8 FIFO, called at a negedge.
  task automatic step8(input string t, input logic p,
                       input logic [W-1:0] d,
                       input logic r, input logic c);
    bit pa, wa;
    push8 = p; din8 = d; pop8 = r; clr8 = c;
    pa = r && (q8.size() > 0);
    wa = p && ((q8.size() < 8) || pa);
    if (pa) void'(q8.pop_front());
    if (wa) q8.push_back(d);
    ovf8_m = (ovf8_m && !c) || (p && !wa);
    unf8_m = (unf8_m && !c) || (r && !pa);
    @(posedge clk);
    @(negedge clk);
    push8 = 1'b0; pop8 = 1'b0; clr8 = 1'b0;
    check8(t);
  endtask

  // One clock of stimulus on the depth-5 FIFO, called at a negedge.
  task automatic step5(input string t, input logic p,
                       input logic [W-1:0] d,
                       input logic r, input logic c);
    bit pa, wa;
    push5 = p; din5 = d; pop5 = r; clr5 = c;
    pa = r && (q5.size() > 0);
    wa = p && ((q5.size() < 5) || pa);
    if (pa) void'(q5.pop_front());
    if (wa) q5.push_back(d);
    ovf5_m = (ovf5_m && !c) || (p && !wa);
    unf5_m = (unf5_m && !c) || (r && !pa);
    @(posedge clk);
    @(negedge clk);
    push5 = 1'b0; pop5 = 1'b0; clr5 = 1'b0;
    check5(t);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check8("reset");
    check5("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill: head stays 0x1, full after the 8th push.
    for (int i = 1; i <= 8; i++)
      step8("fill", 1'b1, W'(i), 1'b0, 1'b0);
    chk("fill_full", 64'(full8), 64'd1);
    chk("fill_head", 64'(dout8), 64'h1);

    // Overflow drops 0xAA.
    step8("ovf", 1'b1, 32'hAA, 1'b0, 1'b0);
    chk("ovf_flag", 64'(ovf8), 64'd1);
    chk("ovf_cnt", 64'(cnt8), 64'd8);
    for (int i = 0; i < 8; i++)
      step8("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain_dout", 64'(dout8), 64'd0);

    // Underflow, then clear both flags.
    step8("unf", 1'b0, '0, 1'b1, 1'b0);
    chk("unf_flag", 64'(unf8), 64'd1);
    step8("clr", 1'b0, '0, 1'b0, 1'b1);
    chk("clr_unf", 64'(unf8), 64'd0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++)
      step8("refill", 1'b1, W'(32'h10 + i), 1'b0, 1'b0);
    step8("pp_full", 1'b1, 32'h55, 1'b1, 1'b0);
    chk("pp_full_cnt", 64'(cnt8), 64'd8);
    chk("pp_full_ovf", 64'(ovf8), 64'd0);
    for (int i = 0; i < 7; i++)
      step8("pp_drain", 1'b0, '0, 1'b1, 1'b0);
    chk("pp_last", 64'(dout8), 64'h55);
    step8("pp_drain", 1'b0, '0, 1'b1, 1'b0);

    // Push and pop together while empty: no bypass.
    step8("pp_empty", 1'b1, 32'h33, 1'b1, 1'b0);
    chk("pp_empty_d", 64'(dout8), 64'h33);
    chk("pp_empty_u", 64'(unf8), 64'd1);

    // Wrap-around at depth 5, steady occupancy of 2.
    step5("w_pre", 1'b1, 32'h100, 1'b0, 1'b0);
    step5("w_pre", 1'b1, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step5("wrap", 1'b1, W'(32'h200 + i), 1'b1, 1'b0);
      chk("wrap_cnt", 64'(cnt5), 64'd2);
    end

    // Reset between edges with three entries queued.
    step8("pre_rst", 1'b1, 32'h44, 1'b0, 1'b0);
    step8("pre_rst", 1'b1, 32'h45, 1'b0, 1'b0);
    chk("pre_rst_cnt", 64'(cnt8), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    q8.delete(); q5.delete();
    ovf8_m = 0; unf8_m = 0; ovf5_m = 0; unf5_m = 0;
    check8("rst_mid");
    check5("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step8("post_rst", 1'b1, 32'h7, 1'b0, 1'b0);
    chk("post_rst_d", 64'(dout8), 64'h7);
    chk("post_rst_c", 64'(cnt8), 64'd1);

    // Random traffic on both depths.
    for (int i = 0; i < 400; i++)
      step8("rnd8", 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 300; i++)
      step5("rnd5", 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
